// File: rtl/sap_program_loader_if.sv
// Stream, W-bus and datapath-control bundle between sap_program_loader and its surroundings.
// The master side is the byte source plus the datapath; the slave side is the loader.
interface sap_program_loader_if;
  logic       start;
  logic       abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bus_in;
  logic [7:0] bus_data;
  logic       bus_drive;
  logic       maddr_latch;
  logic       ram_latch;
  logic       ram_out;
  logic       step;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, abort, in_data, in_valid, bus_in,
    input  in_ready, bus_data, bus_drive, maddr_latch, ram_latch, ram_out,
           step, cpu_hold, busy, done, error
  );

  modport slave (
    input  start, abort, in_data, in_valid, bus_in,
    output in_ready, bus_data, bus_drive, maddr_latch, ram_latch, ram_out,
           step, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/sap_program_loader.sv
// Loads a program image into SAP RAM over the W-bus, two step pulses per byte (MAR, then RAM).
// Optional readback check of every word is enabled with `define SAP_LOADER_VERIFY_EN.
module sap_program_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2,
  parameter int GAP    = 4
) (
  input logic                 clk,
  input logic                 reset,
  sap_program_loader_if.slave lif
);

  localparam int PH_LEN = SETTLE + 1 + GAP;
  localparam int TW     = $clog2(PH_LEN);
  localparam logic [TW-1:0]     STEP_AT  = TW'(SETTLE);
  localparam logic [TW-1:0]     PH_LAST  = TW'(PH_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_BYTE, ADDR_PH, DATA_PH, VERIFY_PH, NEXT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        byte_q, byte_d;
  logic              error_q, error_d;
  logic              phase_last;

  assign phase_last = (timer_q == PH_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (lif.start && !lif.abort) begin
          state_d = WAIT_BYTE;
          timer_d = '0;
          addr_d  = '0;
          error_d = 1'b0;
        end
      end
      WAIT_BYTE: begin
        if (lif.in_valid) begin
          byte_d  = lif.in_data;
          state_d = ADDR_PH;
          timer_d = '0;
        end
      end
      ADDR_PH: begin
        timer_d = phase_last ? '0 : timer_q + TW'(1);
        if (phase_last) state_d = DATA_PH;
      end
      DATA_PH: begin
        timer_d = phase_last ? '0 : timer_q + TW'(1);
`ifdef SAP_LOADER_VERIFY_EN
        if (phase_last) state_d = VERIFY_PH;
`else
        if (phase_last) state_d = NEXT;
`endif
      end
`ifdef SAP_LOADER_VERIFY_EN
      VERIFY_PH: begin
        timer_d = phase_last ? '0 : timer_q + TW'(1);
        if (phase_last) begin
          state_d = NEXT;
          if (lif.bus_in != byte_q) error_d = 1'b1;
        end
      end
`endif
      NEXT: begin
        if (addr_q == ADDR_END) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = WAIT_BYTE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort cancels any run in flight, including a readback compare on the same cycle.
    if (lif.abort && state_q != IDLE) begin
      state_d = IDLE;
      timer_d = '0;
      addr_d  = addr_q;
      byte_d  = byte_q;
      error_d = error_q;
    end
  end

  always_comb begin
    lif.in_ready    = (state_q == WAIT_BYTE);
    lif.bus_drive   = (state_q == ADDR_PH) || (state_q == DATA_PH);
    lif.maddr_latch = (state_q == ADDR_PH);
    lif.ram_latch   = (state_q == DATA_PH);
    lif.step        = lif.bus_drive && (timer_q == STEP_AT);
    lif.busy        = (state_q != IDLE);
    lif.cpu_hold    = (state_q != IDLE);
    lif.done        = (state_q == DONE);
    lif.bus_data    = 8'h00;
    if (state_q == ADDR_PH) lif.bus_data = 8'(addr_q);
    if (state_q == DATA_PH) lif.bus_data = byte_q;
`ifdef SAP_LOADER_VERIFY_EN
    lif.ram_out     = (state_q == VERIFY_PH);
`else
    lif.ram_out     = 1'b0;
`endif
    lif.error       = error_q;
  end

`ifndef SAP_LOADER_VERIFY_EN
  logic unused_bus_in;
  assign unused_bus_in = ^lif.bus_in;
`endif

endmodule
